// File: rtl/param_bank_sequencer_if.sv
// Router-side cache port plus downstream valid/ready word stream of the bank sequencer.
// The sequencer connects through master; the router model and stream sink connect through slave.
interface param_bank_sequencer_if;
  logic [1:0]  sel;
  logic        critical;
  logic [15:0] proce_Addr;
  logic        proce_WE;
  logic [15:0] proce_DataIn;
  logic [15:0] proce_DataOut;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_bank;
  logic        out_last;

  modport master (
    output sel, critical, proce_Addr, proce_WE, proce_DataIn,
    output out_data, out_valid, out_bank, out_last,
    input  proce_DataOut, out_ready
  );

  modport slave (
    input  sel, critical, proce_Addr, proce_WE, proce_DataIn,
    input  out_data, out_valid, out_bank, out_last,
    output proce_DataOut, out_ready
  );
endinterface

// File: rtl/param_bank_sequencer.sv
// Sweeps the four parameter cache banks through mod_ParamRouter and streams every word downstream.
// Optional per-bank checksum outputs are built when PARAM_CHECKSUM_EN is defined.
module param_bank_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
`ifdef PARAM_CHECKSUM_EN
  output logic        done,
  output logic [15:0] bank_sum,
  output logic        bank_sum_valid,
`else
  output logic done,
`endif
  param_bank_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_LATCH, S_HOLD, S_GAP, S_DONE
  } state_t;

  localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);
  localparam int unsigned GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  state_t           state_q, state_d;
  logic [1:0]       bank_q;
  logic [15:0]      addr_q;
  logic [GAP_W-1:0] gap_q;
  logic [1:0]       sel_q;
  logic             crit_q;
  logic             busy_q;
  logic [15:0]      out_data_q;
  logic             out_valid_q;
  logic [1:0]       out_bank_q;
  logic             out_last_q;

  logic last_addr;
  logic handshake;
  logic gap_done;
  logic bank_start;

  assign last_addr  = (addr_q == LAST_ADDR);
  assign handshake  = (state_q == S_HOLD) && bus.out_ready;
  assign gap_done   = (gap_q == GAP_W'(1));
  assign bank_start = ((state_q == S_IDLE) && start) || ((state_q == S_GAP) && gap_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: next state gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: state_d = S_HOLD;
      S_HOLD: begin
        if (bus.out_ready) begin
          if (!last_addr)          state_d = S_ISSUE;
          else if (bank_q != 2'd3) state_d = S_GAP;
          else                     state_d = S_DONE;
        end
      end
      S_GAP:   if (gap_done) state_d = S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q      <= '0;
      addr_q      <= '0;
      gap_q       <= '0;
      sel_q       <= '0;
      crit_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_bank_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (abort) begin
      bank_q      <= '0;
      addr_q      <= '0;
      gap_q       <= '0;
      sel_q       <= '0;
      crit_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bank_q <= '0;
            addr_q <= '0;
            sel_q  <= '0;
            crit_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        S_LATCH: begin
          out_data_q  <= bus.proce_DataOut;
          out_bank_q  <= bank_q;
          out_last_q  <= last_addr;
          out_valid_q <= 1'b1;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (!last_addr) begin
              addr_q <= addr_q + 16'd1;
            end else if (bank_q != 2'd3) begin
              // sel moves only on the edge that drops critical, so the router never sees a bank swap mid-access
              crit_q <= 1'b0;
              bank_q <= bank_q + 2'd1;
              sel_q  <= bank_q + 2'd1;
              gap_q  <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          gap_q <= gap_q - GAP_W'(1);
          if (gap_done) begin
            crit_q <= 1'b1;
            addr_q <= '0;
          end
        end
        S_DONE: begin
          crit_q <= 1'b0;
          busy_q <= 1'b0;
          sel_q  <= '0;
          bank_q <= '0;
          addr_q <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef PARAM_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        sum_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else if (abort) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= handshake && out_last_q;
      if (bank_start)     sum_q <= '0;
      else if (handshake) sum_q <= sum_q + out_data_q;
    end
  end

  assign bank_sum       = sum_q;
  assign bank_sum_valid = sum_valid_q;
`endif

  assign busy              = busy_q;
  assign done              = (state_q == S_DONE);
  assign bus.sel           = sel_q;
  assign bus.critical      = crit_q;
  assign bus.proce_Addr    = BASE_ADDR + addr_q;
  assign bus.proce_WE      = 1'b0;
  assign bus.proce_DataIn  = 16'h0000;
  assign bus.out_data      = out_data_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_bank      = out_bank_q;
  assign bus.out_last      = out_last_q;

endmodule

// File: tb/tb_param_bank_sequencer.sv
// Directed bench for param_bank_sequencer: a one-cycle-latency router model feeds a word scoreboard.
module tb_param_bank_sequencer;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hfffe;
  localparam int          GAP   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
`ifdef PARAM_CHECKSUM_EN
  logic [15:0] bank_sum;
  logic        bank_sum_valid;
`endif

  param_bank_sequencer_if bus();

  param_bank_sequencer #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
`ifdef PARAM_CHECKSUM_EN
    .bank_sum(bank_sum),
    .bank_sum_valid(bank_sum_valid),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  bank;
    logic        last;
    logic [15:0] addr;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          b0_mode = 1'b0;
  logic [15:0] b0_tbl [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [1:0] b, input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    case (b)
      2'd0:    model_word = b0_mode ? b0_tbl[off[1:0]] : 16'haaaa;
      2'd1:    model_word = 16'hbbbb;
      2'd2:    model_word = a + 16'h1000;
      default: model_word = 16'hdddd;
    endcase
  endfunction

  // Registered router read: the user port owns the caches whenever critical is low.
  always_ff @(posedge clk)
    bus.proce_DataOut <= bus.critical ? model_word(bus.sel, bus.proce_Addr) : 16'hdead;

  task automatic load_scoreboard();
    exp_t e;
    q.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < DEPTH; i++) begin
        e.addr = BASE + 16'(i);
        e.bank = 2'(b);
        e.data = model_word(e.bank, e.addr);
        e.last = (i == DEPTH - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_busy", busy, 1);
    check("start_critical", bus.critical, 1);
    check("start_addr", bus.proce_Addr, BASE);
    check("start_sel", bus.sel, 0);
    @(posedge clk); #1 check("lat_k1_valid", bus.out_valid, 0);
    @(posedge clk); #1 check("lat_k2_valid", bus.out_valid, 0);
    @(posedge clk); #1 check("lat_k3_valid", bus.out_valid, 1);
  endtask

  task automatic run_sweep(input int stall_word, input int abort_bank, input int reset_bank);
    int          word_idx = 0;
    int          stall_left = 10;
    int          gap_len = 0;
    int          gaps = 0;
    bit          prev_crit = 1'b1;
    logic [1:0]  prev_sel = 2'd0;
    bit          finished = 1'b0;
    bit          pend_pulse = 1'b0;
    logic [1:0]  pend_bank = 2'd0;
    logic [15:0] sum = 16'h0;
    logic [15:0] sum_final = 16'h0;
    exp_t        e;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      check("we_tied", bus.proce_WE, 0);
      check("din_tied", bus.proce_DataIn, 0);
      if (bus.sel != prev_sel) check("sel_on_crit_fall", {prev_crit, bus.critical}, 2'b10);
      if (!bus.critical && busy) gap_len++;
      if (bus.critical && !prev_crit) begin
        check("gap_len", gap_len, GAP);
        gap_len = 0;
        gaps++;
      end
      prev_crit = bus.critical;
      prev_sel  = bus.sel;
`ifdef PARAM_CHECKSUM_EN
      check("sum_valid", bank_sum_valid, pend_pulse);
      if (pend_pulse) begin
        check("bank_sum", bank_sum, sum_final);
        if (b0_mode && pend_bank == 2'd0) check("bank0_sum_5", bank_sum, 16'h0005);
      end
`endif
      pend_pulse = 1'b0;
      if (abort_bank >= 0 && bus.out_valid && bus.out_bank == 2'(abort_bank)) begin
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_critical", bus.critical, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sel", bus.sel, 0);
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
          check("abort_stays_idle", {busy, bus.critical}, 2'b00);
        end
        q.delete();
        finished = 1'b1;
      end else if (reset_bank >= 0 && bus.out_valid && bus.out_bank == 2'(reset_bank)) begin
        rst = 1'b1;
        #1;
        check("reset_critical", bus.critical, 0);
        check("reset_valid", bus.out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sel", bus.sel, 0);
        check("reset_addr", bus.proce_Addr, BASE);
        check("reset_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        finished = 1'b1;
      end else if (done) begin
        check("done_busy", busy, 1);
        check("done_queue_empty", q.size(), 0);
        check("done_gaps", gaps, 3);
        @(negedge clk);
        check("post_done_pulse", done, 0);
        check("post_done_busy", busy, 0);
        check("post_done_critical", bus.critical, 0);
        check("post_done_sel", bus.sel, 0);
        finished = 1'b1;
      end else begin
        if (word_idx == stall_word && bus.out_valid && stall_left > 0) begin
          bus.out_ready = 1'b0;
          start = (stall_left == 5);
          check("stall_data", bus.out_data, q[0].data);
          check("stall_addr", bus.proce_Addr, q[0].addr);
          check("stall_critical", bus.critical, 1);
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
          start = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_word", 1, 0);
          end else begin
            e = q.pop_front();
            check("word_data", bus.out_data, e.data);
            check("word_bank", bus.out_bank, e.bank);
            check("word_last", bus.out_last, e.last);
            check("word_addr", bus.proce_Addr, e.addr);
            sum = sum + e.data;
            if (e.last) begin
              pend_pulse = 1'b1;
              pend_bank  = e.bank;
              sum_final  = sum;
              sum        = 16'h0;
            end
          end
          word_idx++;
        end
      end
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    check("sweep_terminated", finished, 1);
  endtask

  initial begin
    b0_tbl[0] = 16'h0001;
    b0_tbl[1] = 16'h0002;
    b0_tbl[2] = 16'h0003;
    b0_tbl[3] = 16'hffff;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", bus.sel, 0);
    check("rst_critical", bus.critical, 0);
    check("rst_addr", bus.proce_Addr, BASE);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_bank", bus.out_bank, 0);
    check("rst_data", bus.out_data, 0);
    rst = 1'b0;

    // start and abort together from idle: abort wins
    @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    check("start_abort_busy", busy, 0);
    check("start_abort_critical", bus.critical, 0);
    repeat (3) @(posedge clk);
    #1 check("start_abort_idle", bus.out_valid, 0);

    load_scoreboard();
    pulse_start();
    run_sweep(-1, -1, -1);

    load_scoreboard();
    pulse_start();
    run_sweep(1, -1, -1);

    load_scoreboard();
    pulse_start();
    run_sweep(-1, 1, -1);

    load_scoreboard();
    pulse_start();
    run_sweep(-1, -1, 2);

    b0_mode = 1'b1;
    load_scoreboard();
    pulse_start();
    run_sweep(-1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_bank_sequencer.md
Name: param_bank_sequencer

Overview:
- Processor-side master directly upstream of mod_ParamRouter.
- Drives sel, critical, proce_Addr, proce_WE and proce_DataIn into the router, and reads proce_DataOut back.
- On start, sweeps all four parameter cache banks in order and streams each word downstream over a valid/ready interface.
- Releases critical for a fixed gap between banks so the user port regains cache access.

Parameters:
- DEPTH, 16, words read per bank (1..65536).
- BASE_ADDR, 16'h0000, first address read in every bank.
- GAP_CYCLES, 4, cycles critical is held low between banks (minimum 1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep; ignored unless busy=0
- abort  in  1  cancels an in-progress sweep
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last word of bank 3 is accepted
- sel  out  2  bank select to router
- critical  out  1  processor owns caches when 1
- proce_Addr  out  16  cache address to router
- proce_WE  out  1  tied 0 (read-only sequencer)
- proce_DataIn  out  16  tied 16'h0000
- proce_DataOut  in  16  read data from router; valid one cycle after proce_Addr
- out_data  out  16  streamed parameter word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid&&out_ready
- out_bank  out  2  bank of current out_data
- out_last  out  1  high with the final word of each bank

Behaviour:
- Reset (async, any time, including mid-sweep): state IDLE; sel=0, critical=0, proce_Addr=BASE_ADDR, all other outputs 0, internal counters 0.
- Cache read latency is 1 cycle: data for the address presented in cycle n is valid on proce_DataOut in cycle n+1.
- States and transitions:
  - IDLE: critical=0. start=1 → ISSUE; bank=0, addr=0, critical=1, busy=1.
  - ISSUE: proce_Addr=BASE_ADDR+addr (16-bit wrap). → WAIT.
  - WAIT: → LATCH.
  - LATCH: out_data<=proce_DataOut, out_bank<=bank, out_last<=(addr==DEPTH-1), out_valid<=1. → HOLD.
  - HOLD: out_valid held and out_data stable until out_ready=1. On the handshake out_valid<=0, then:
    - addr<DEPTH-1: addr++, → ISSUE.
    - last addr, bank<3: critical<=0, bank++, sel<=bank+1, gap counter=GAP_CYCLES, → GAP.
    - last addr, bank==3: → DONE.
  - GAP: critical=0. Decrement the counter each cycle; at 0, critical<=1, addr=0, → ISSUE. sel changes only in the cycle critical falls, never while critical=1.
  - DONE: done=1 for one cycle, critical<=0, busy<=0, sel<=0. → IDLE.
- Latency: start sampled at edge k; critical=1 and proce_Addr=BASE_ADDR from k+1; first out_valid rises after edge k+3.
- abort: takes priority over all transitions. Next cycle: IDLE, critical=0, out_valid=0, busy=0, no done pulse.
- start while busy=1: ignored.
- start and abort in the same cycle from IDLE: abort wins, stays IDLE.
- DEPTH=1: every word has out_last=1.
- out_ready held low: sequencer stalls in HOLD indefinitely with critical=1.

Optional Feature:
- Macro PARAM_CHECKSUM_EN.
- With it, adds outputs bank_sum[15:0] and bank_sum_valid.
  - bank_sum accumulates the modulo-2^16 sum of accepted words of the current bank.
  - bank_sum_valid pulses one cycle, with the final sum, on the cycle after the out_last handshake.
  - The accumulator clears at each bank start, on reset and on abort.
- Without it, these ports and the logic do not exist; all other behaviour is identical.

Test Plan:
- Router-model banks hold 16'haaaa/bbbb/cccc/dddd at every address, DEPTH=4, out_ready=1, pulse start → 16 words: four of each value in bank order, out_bank 0..3, out_last on words 4/8/12/16, single done pulse, busy falls with done.
- Same setup, GAP_CYCLES=4 → critical low exactly 4 cycles between banks; sel changes only on the cycle critical falls; proce_WE always 0.
- Bank 2 address-dependent data (addr+16'h1000), BASE_ADDR=16'hfffe, DEPTH=4 → proce_Addr fffe, ffff, 0000, 0001; out_data 0ffe, 0fff, 1000, 1001.
- out_ready held low 10 cycles on word 2 → out_valid and out_data stable, critical stays 1, no address advance; resumes correctly on release.
- abort asserted mid-bank-1, then reset asserted mid-bank-2 on a fresh sweep → each time critical=0, out_valid=0 next cycle (reset: immediately), no done; new start restarts at bank 0, addr 0.
- PARAM_CHECKSUM_EN, DEPTH=4, bank 0 words 1,2,3,16'hffff → bank_sum=16'h0005, one bank_sum_valid pulse per bank.
